// File: rtl/event_pulse_stretcher_pkg.sv
// Shared definitions for the event pulse stretcher: state encoding,
// default 50 MHz timing and the timing-counter width helper.
package event_pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  // 50 ms on / 50 ms off at a 50 MHz clock.
  localparam int DEFAULT_ON_CYCLES  = 2_500_000;
  localparam int DEFAULT_OFF_CYCLES = 2_500_000;

  function automatic int cnt_width(input int on_c, input int off_c);
    int m;
    m = (on_c > off_c) ? on_c : off_c;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/event_pulse_stretcher_sat_counter.sv
// Up/down counter that holds at zero and at all-ones; a sticky flag
// records any increment lost at the top.
module event_pulse_stretcher_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count_reg;
  logic         sat_reg;

  // Simultaneous inc and dec cancel, so a full counter can still accept
  // an event in the same cycle one is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      sat_reg   <= 1'b0;
    end else if (inc && !dec) begin
      if (count_reg == MAX)
        sat_reg <= 1'b1;
      else
        count_reg <= count_reg + 1'b1;
    end else if (dec && !inc && count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign sat   = sat_reg;

endmodule

// File: rtl/event_pulse_stretcher.sv
// Stretches single-cycle event strobes into visible LED pulses with a
// guaranteed off-gap; events arriving mid-pulse are queued and replayed.
module event_pulse_stretcher
  import event_pulse_stretcher_pkg::*;
#(
  parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
  parameter int OFF_CYCLES = DEFAULT_OFF_CYCLES,
  parameter int PEND_W     = 4,
  parameter int RETRIGGER  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              event_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int CNT_W = cnt_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             led_reg, led_next;
  logic             busy_reg, busy_next;
  logic             cnt_zero;
  logic             pend_inc, pend_dec;
  logic             pend_nonzero;

  assign cnt_zero     = (cnt_reg == '0);
  assign pend_nonzero = (pending != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      led_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      led_reg   <= led_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (event_in) begin
          state_next = ON;
          cnt_next   = ON_LOAD;
        end
      end
      ON: begin
        if (RETRIGGER != 0 && event_in) begin
          cnt_next = ON_LOAD;
        end else if (!cnt_zero) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          state_next = GAP;
          cnt_next   = OFF_LOAD;
        end
      end
      GAP: begin
        if (!cnt_zero) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (pend_nonzero || event_in) begin
          state_next = ON;
          cnt_next   = ON_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // On the gap-exit cycle an arriving event and the consumed one cancel,
  // which also covers showing a fresh event directly when the queue is empty.
  always_comb begin
    led_next  = (state_next == ON);
    busy_next = (state_next != IDLE);
    pend_inc  = 1'b0;
    pend_dec  = 1'b0;
    case (state_reg)
      ON:  pend_inc = event_in && (RETRIGGER == 0);
      GAP: begin
        pend_inc = event_in;
        pend_dec = cnt_zero && (pend_nonzero || event_in);
      end
      default: ;
    endcase
  end

  event_pulse_stretcher_sat_counter #(
    .W(PEND_W)
  ) u_pending (
    .clk  (clk),
    .reset(reset),
    .inc  (pend_inc),
    .dec  (pend_dec),
    .count(pending),
    .sat  (overflow)
  );

  assign led_out = led_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_event_pulse_stretcher.sv
// Directed bench: expected LED pulses go into a scoreboard queue and a
// monitor measures each observed pulse; status outputs are checked inline.
module tb_event_pulse_stretcher;

  localparam int ON_C  = 4;
  localparam int OFF_C = 3;
  localparam int PW    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ev_a = 1'b0;
  logic          ev_b = 1'b0;
  logic          led_a, busy_a, ovf_a;
  logic          led_b, busy_b, ovf_b;
  logic [PW-1:0] pend_a, pend_b;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int b        = 0;
  bit sel_b    = 1'b0;

  typedef struct {
    int start;
    int width;
  } pulse_t;

  pulse_t exp_q[$];

  event_pulse_stretcher #(
    .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .PEND_W(PW), .RETRIGGER(0)
  ) dut_a (
    .clk(clk), .reset(reset), .event_in(ev_a),
    .led_out(led_a), .busy(busy_a), .pending(pend_a), .overflow(ovf_a)
  );

  event_pulse_stretcher #(
    .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .PEND_W(PW), .RETRIGGER(1)
  ) dut_b (
    .clk(clk), .reset(reset), .event_in(ev_b),
    .led_out(led_b), .busy(busy_b), .pending(pend_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end else begin
      $display("check %s: %0d ok (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: one transaction per observed LED pulse.
  initial begin
    int  start_c;
    bit  in_p;
    logic l;
    pulse_t e;
    in_p = 1'b0;
    start_c = 0;
    forever begin
      @(negedge clk);
      l = sel_b ? led_b : led_a;
      if (reset) begin
        in_p = 1'b0;
      end else if (l && !in_p) begin
        in_p = 1'b1;
        start_c = cyc;
      end else if (!l && in_p) begin
        in_p = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse_start", start_c, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_start", start_c - b, e.start - b);
          chk("pulse_width", cyc - start_c, e.width);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int start, input int width);
    pulse_t p;
    p.start = start;
    p.width = width;
    exp_q.push_back(p);
  endtask

  task automatic pulse_a(input int c);
    wait_cyc(c);
    ev_a = 1'b1;
    @(posedge clk);
    #1;
    ev_a = 1'b0;
  endtask

  task automatic pulse_b(input int c);
    wait_cyc(c);
    ev_b = 1'b1;
    @(posedge clk);
    #1;
    ev_b = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    b = cyc;
  endtask

  initial begin
    // Scenario 1: single event, plus reset state
    do_reset();
    chk("reset_led", led_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_pending", pend_a, 0);
    chk("reset_overflow", ovf_a, 0);
    push(b + 11, ON_C);
    pulse_a(b + 10);
    wait_cyc(b + 12); chk("s1_pending", pend_a, 0);
    wait_cyc(b + 17); chk("s1_busy_last", busy_a, 1);
    wait_cyc(b + 18); chk("s1_busy_clear", busy_a, 0);
    wait_cyc(b + 25); chk("s1_queue_empty", exp_q.size(), 0);

    // Scenario 2: queued events replayed with exact gaps
    do_reset();
    push(b + 11, ON_C); push(b + 18, ON_C); push(b + 25, ON_C);
    pulse_a(b + 10);
    pulse_a(b + 12);
    wait_cyc(b + 13); chk("s2_pending_1", pend_a, 1);
    pulse_a(b + 16);
    wait_cyc(b + 17); chk("s2_pending_peak", pend_a, 2);
    wait_cyc(b + 18); chk("s2_pending_after_exit", pend_a, 1);
    wait_cyc(b + 25); chk("s2_pending_drained", pend_a, 0);
    wait_cyc(b + 35); chk("s2_queue_empty", exp_q.size(), 0);

    // Scenario 3: held level saturates the queue
    do_reset();
    push(b + 11, ON_C); push(b + 18, ON_C); push(b + 25, ON_C); push(b + 32, ON_C);
    wait_cyc(b + 10);
    ev_a = 1'b1;
    wait_cyc(b + 14); chk("s3_pending_sat", pend_a, 3); chk("s3_ovf_before", ovf_a, 0);
    wait_cyc(b + 15); chk("s3_ovf_set", ovf_a, 1);
    wait_cyc(b + 16);
    ev_a = 1'b0;
    wait_cyc(b + 40); chk("s3_ovf_sticky", ovf_a, 1); chk("s3_pending_end", pend_a, 0);
    wait_cyc(b + 42); chk("s3_queue_empty", exp_q.size(), 0);

    // Scenario 4: retrigger extends the pulse
    do_reset();
    sel_b = 1'b1;
    push(b + 11, 7);
    pulse_b(b + 10);
    pulse_b(b + 13);
    wait_cyc(b + 14); chk("s4_pending", pend_b, 0);
    wait_cyc(b + 20); chk("s4_busy_gap", busy_b, 1);
    wait_cyc(b + 21); chk("s4_busy_clear", busy_b, 0);
    wait_cyc(b + 28); chk("s4_queue_empty", exp_q.size(), 0);
    sel_b = 1'b0;

    // Scenario 5: event on the gap-exit cycle starts a pulse directly
    do_reset();
    push(b + 11, ON_C); push(b + 18, ON_C);
    pulse_a(b + 10);
    pulse_a(b + 17);
    wait_cyc(b + 18); chk("s5_pending", pend_a, 0);
    wait_cyc(b + 24); chk("s5_busy_gap", busy_a, 1);
    wait_cyc(b + 25); chk("s5_busy_clear", busy_a, 0);
    wait_cyc(b + 28); chk("s5_queue_empty", exp_q.size(), 0);

    // Scenario 6: asynchronous reset mid-pulse discards the queue
    do_reset();
    pulse_a(b + 10);
    pulse_a(b + 12);
    pulse_a(b + 13);
    wait_cyc(b + 14); chk("s6_pending_before", pend_a, 2); chk("s6_led_before", led_a, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("s6_async_led", led_a, 0);
    chk("s6_async_busy", busy_a, 0);
    chk("s6_async_pending", pend_a, 0);
    chk("s6_async_overflow", ovf_a, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    b = cyc;
    push(b + 11, ON_C);
    pulse_a(b + 10);
    wait_cyc(b + 17); chk("s6_busy_last", busy_a, 1);
    wait_cyc(b + 18); chk("s6_busy_clear", busy_a, 0);
    wait_cyc(b + 22); chk("s6_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/event_pulse_stretcher.md
Name: event_pulse_stretcher

Overview:
- Output-side counterpart of the button input synchronizer.
- Takes single-cycle, clock-synchronous event strobes from internal logic and drives a board output pin (LED or test header) with human-visible pulses of fixed on-time, separated by a guaranteed off-gap.
- Events that arrive while a pulse or gap is in progress are queued and replayed as separate blinks, so none are merged silently.
- Sits between ADC control/status logic and the DE10-Standard LED pins.

Parameters:
- ON_CYCLES, 2500000, clk cycles led_out is held high per event; must be >= 1.
- OFF_CYCLES, 2500000, minimum clk cycles led_out is held low between consecutive pulses; must be >= 1.
- PEND_W, 4, width of the pending-event counter; saturates at 2^PEND_W-1.
- RETRIGGER, 0, when 1, an event during ON reloads the on-time instead of queuing.

Ports:
- clk, input, 1, system clock (PLL output).
- reset, input, 1, asynchronous, active-high reset.
- event_in, input, 1, synchronous event strobe; each cycle it is high counts as one event.
- led_out, output, 1, stretched pulse to the pin; registered.
- busy, output, 1, high whenever the state is not IDLE; registered.
- pending, output, PEND_W, number of queued events not yet shown.
- overflow, output, 1, sticky flag: an event was lost because pending was saturated.

Behaviour:
- Reset (async assert, sync release): led_out=0, busy=0, pending=0, overflow=0, state=IDLE, cnt=0.
- Down-counter cnt is $clog2(max(ON_CYCLES,OFF_CYCLES)) bits wide, with at least 1 bit.
- States: IDLE, ON, GAP.
- IDLE:
  - event_in=1 -> next cycle state=ON, led_out=1, busy=1, cnt=ON_CYCLES-1.
  - Latency from event to led_out high is exactly 1 cycle.
- ON:
  - cnt!=0 -> cnt decrements.
  - cnt==0 -> state=GAP, led_out=0, cnt=OFF_CYCLES-1.
  - led_out is therefore high for exactly ON_CYCLES consecutive cycles.
- GAP:
  - cnt!=0 -> cnt decrements.
  - cnt==0 and (pending!=0 or event_in) -> state=ON, led_out=1, cnt=ON_CYCLES-1, and one event is consumed.
  - cnt==0 otherwise -> state=IDLE, busy=0.
  - led_out is low for exactly OFF_CYCLES cycles between pulses.
- Queuing, RETRIGGER=0: event_in=1 in ON or GAP increments pending, except in the GAP-exit cycle.
- Queuing, RETRIGGER=1:
  - event_in=1 in ON reloads cnt=ON_CYCLES-1; pending is unchanged and the pulse is extended.
  - event_in=1 in GAP queues as in RETRIGGER=0.
- GAP-exit cycle with event_in=1: the new event is consumed directly if pending==0; otherwise pending is unchanged (+1 −1).
- Saturation: event_in=1 with pending==2^PEND_W-1 and no simultaneous consume -> pending holds and overflow goes to 1. overflow clears only on reset.
- The event in the IDLE->ON cycle is the one being shown; it never enters pending.
- Reset mid-pulse: led_out drops immediately (async) and the queue is discarded.
- event_in must already be synchronous to clk; no internal synchronizer or edge detection. A level held high for N cycles counts as N events.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, ON=2'd1, GAP=2'd2;
  - default timing constants (ON_CYCLES/OFF_CYCLES for 50 MHz).
- One natural sub-module: sat_counter (parameterised-width up/down counter with saturation flag), used for pending.
- Timing counter and FSM stay in the top module.

Test Plan (ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2, RETRIGGER=0 unless stated):
- Single event_in pulse at cycle 10 -> led_out high cycles 11-14, low from 15; busy high 11-17, 0 at 18; pending stays 0.
- Events at cycles 10, 12, 16 -> led_out high 11-14, 18-21, 25-28; pending peaks at 2 and reaches 0 at 25; each gap is exactly 3 cycles.
- event_in held high 6 cycles from cycle 10 -> pending saturates at 3, overflow=1 at cycle 15 and stays 1; three further pulses follow the first.
- RETRIGGER=1: events at cycles 10 and 13 -> led_out high 11-17 (reloaded), then low 3 cycles; pending stays 0.
- Event exactly in the GAP-exit cycle with pending=0 -> immediate new ON with no extra gap cycle; pending stays 0.
- Assert reset asynchronously mid-ON with pending=2 -> led_out, busy, pending, overflow all 0 before the next clk edge; next event behaves as in the first scenario.
